// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte sources.
// One byte per grant, with a watchdog that frees the transmitter if tx_done never comes.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic               err_timeout,
    output logic               arb_busy,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t        state_r;
    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] win_r;
    logic [WW-1:0] wd_r;

    logic          win_found_s;
    logic [PW-1:0] win_idx_s;
    logic [PW-1:0] rr_cand_s;
    logic [7:0]    win_data_s;
    logic [PW-1:0] next_ptr_s;

    function automatic logic [N_REQ-1:0] to_onehot(input logic [PW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Cyclic first-set search of req starting at rr_ptr_r
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        rr_cand_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_cand_s = PW'((int'(rr_ptr_r) + k) % N_REQ);
            if (!win_found_s && req[rr_cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = rr_cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Byte of the current search winner
    always_comb begin
        win_data_s = 8'h00;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_idx_s == PW'(j)) begin
                win_data_s = req_data[8*j +: 8];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Pointer moves past the served requester; explicit wrap keeps non-power-of-2 N_REQ correct
    always_comb begin
        if (win_r == PTR_LAST) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_r + PW'(1);
        end
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            win_r       <= '0;
            wd_r        <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant       <= '0;
            ack         <= '0;
            err_timeout <= 1'b0;
            arb_busy    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s && !tx_busy) begin
                        grant    <= to_onehot(win_idx_s);
                        win_r    <= win_idx_s;
                        tx_data  <= win_data_s;
                        tx_start <= 1'b1;
                        arb_busy <= 1'b1;
                        state_r  <= ST_ISSUE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    tx_start <= 1'b0;
                    wd_r     <= '0;
                    state_r  <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // tx_done has priority over a watchdog expiry on the same cycle
                    if (tx_done) begin
                        ack      <= to_onehot(win_r);
                        grant    <= '0;
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= ST_GAP;
                    end else if (wd_r == WD_LAST) begin
                        err_timeout <= 1'b1;
                        grant       <= '0;
                        rr_ptr_r    <= next_ptr_s;
                        state_r     <= ST_GAP;
                    end else begin
                        wd_r <= wd_r + WW'(1);
                    end
                end
                ST_GAP: begin
                    ack         <= '0;
                    err_timeout <= 1'b0;
                    arb_busy    <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    tx_start    <= 1'b0;
                    grant       <= '0;
                    ack         <= '0;
                    err_timeout <= 1'b0;
                    arb_busy    <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a timestamp-based transaction model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           err_timeout;
    logic           arb_busy;
    logic           tx_start;
    logic [7:0]     tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .ack(ack), .grant(grant), .err_timeout(err_timeout), .arb_busy(arb_busy),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- transaction model (timestamps per transfer) ----------------
    int        cyc = 0;
    bit        m_active = 1'b0;
    int        m_owner = 0, m_t0 = -10, m_fin = -1, m_rr = 0, m_ready = 0;
    bit        m_fin_ack = 1'b0;
    logic [7:0] m_data = 8'h00;

    initial begin
        logic [N-1:0] e_grant, e_ack;
        int w;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                m_active = 1'b0; m_fin = -1; m_rr = 0; m_data = 8'h00; m_ready = 0; m_t0 = -10;
            end else begin
                e_grant = (m_active && cyc >= m_t0 && (m_fin < 0 || cyc < m_fin)) ? (N'(1) << m_owner) : '0;
                e_ack   = (m_fin == cyc && m_fin_ack) ? (N'(1) << m_owner) : '0;
                chk("cyc_tx_start", tx_start, (m_active && cyc == m_t0));
                chk("cyc_grant", grant, e_grant);
                chk("cyc_ack", ack, e_ack);
                chk("cyc_err", err_timeout, (m_fin == cyc && !m_fin_ack));
                chk("cyc_busy", arb_busy, m_active);
                chk("cyc_tx_data", tx_data, m_data);
                if (m_active) begin
                    if (m_fin < 0) begin
                        if (cyc >= m_t0 + 1 && tx_done) begin
                            m_fin = cyc + 1; m_fin_ack = 1'b1;
                        end else if (cyc == m_t0 + TO) begin
                            m_fin = cyc + 1; m_fin_ack = 1'b0;
                        end
                        if (m_fin > 0) begin
                            m_rr = (m_owner + 1) % N;
                            m_ready = m_fin + 1;
                        end
                    end else if (cyc == m_fin) begin
                        m_active = 1'b0;
                    end
                end else if (cyc >= m_ready && req != '0 && !tx_busy) begin
                    w = rr_pick(req, m_rr);
                    m_owner = w; m_t0 = cyc + 1; m_fin = -1; m_active = 1'b1;
                    m_data = 8'(req_data >> (8 * w));
                end
            end
        end
    end

    // ---------------- uart_tx stand-in ----------------
    bit force_busy = 1'b0, kill_mode = 1'b0, rand_uart = 1'b0;
    int frame_len = 12;

    initial begin
        int cnt = 0;
        bit s, kill_cur;
        kill_cur = 1'b0;
        forever begin
            @(negedge clk);
            s = tx_start;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                cnt = 0; tx_done = 1'b0; tx_busy = force_busy;
            end else begin
                tx_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && !kill_cur) tx_done = 1'b1;
                end else if (rand_uart && !s && $urandom_range(0, 15) == 0) begin
                    tx_done = 1'b1;
                end
                if (s) begin
                    cnt = rand_uart ? int'($urandom_range(4, 30)) : frame_len;
                    kill_cur = kill_mode || (rand_uart && $urandom_range(0, 9) == 0);
                end
                tx_busy = (cnt > 0) || force_busy;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_evt(input string name, output int at);
        at = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ack != '0 || err_timeout) begin at = cyc; break; end
        end
        if (at < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_start(input string name, output int at);
        at = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_start) begin at = cyc; break; end
        end
        if (at < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int t_s, t_e;
        logic [N-1:0] s_ack;
        logic [N-1:0] exp_g [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_busy", arb_busy, 1'b0);

        // single request
        @(posedge clk); #2 req = 4'b0010; req_data[15:8] = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        chk("single_grant", grant, 4'b0010);
        chk("single_start", tx_start, 1'b1);
        chk("single_data", tx_data, 8'hA5);
        @(negedge clk);
        chk("single_start_pulse", tx_start, 1'b0);
        wait_evt("single_ack", t_e);
        chk("single_ack", ack, 4'b0010);
        chk("single_data_held", tx_data, 8'hA5);
        @(posedge clk); #2 req = 4'b0000;
        @(negedge clk);
        chk("single_ack_pulse", ack, 4'b0000);

        // simultaneous requests after reset
        do_reset();
        @(posedge clk); #2 req = 4'b1010; req_data = 32'h33_00_11_00;
        wait_evt("simul_ack1", t_s);
        chk("simul_ack1", ack, 4'b0010);
        @(posedge clk); #2 req = 4'b1000;
        wait_evt("simul_ack2", t_e);
        chk("simul_ack2", ack, 4'b1000);
        chk("simul_data2", tx_data, 8'h33);
        chk("simul_gap", (t_e - t_s) > 3, 1'b1);
        @(posedge clk); #2 req = 4'b0000;

        // fairness
        do_reset();
        @(posedge clk); #2 req = 4'b1111; req_data = 32'h33_32_31_30;
        for (int k = 0; k < 8; k++) begin
            wait_start("fair_start", t_s);
            chk("fair_grant", grant, exp_g[k % 4]);
            chk("fair_data", tx_data, 8'h30 + 8'(k % 4));
        end
        wait_evt("fair_last_ack", t_e);
        @(posedge clk); #2 req = 4'b0000;

        // watchdog
        do_reset();
        kill_mode = 1'b1;
        @(posedge clk); #2 req = 4'b0001;
        wait_start("wd_start", t_s);
        wait_evt("wd_err", t_e);
        chk("wd_err", err_timeout, 1'b1);
        chk("wd_no_ack", ack, 4'b0000);
        chk("wd_latency", t_e - t_s, TO + 1);
        @(posedge clk); #2 req = 4'b0011; req_data[15:8] = 8'h5A; kill_mode = 1'b0;
        wait_start("wd_next", t_s);
        chk("wd_next_grant", grant, 4'b0010);
        chk("wd_next_data", tx_data, 8'h5A);
        wait_evt("wd_next_ack", t_e);
        chk("wd_next_ack", ack, 4'b0010);
        @(posedge clk); #2 req = 4'b0000;

        // busy gating
        @(posedge clk); #2 force_busy = 1'b1;
        @(posedge clk); #2 req = 4'b0100; req_data[23:16] = 8'hC3;
        repeat (5) begin
            @(negedge clk);
            chk("busy_no_start", tx_start, 1'b0);
            chk("busy_arb_busy", arb_busy, 1'b0);
        end
        @(posedge clk); #2 force_busy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("busy_release_grant", grant, 4'b0100);
        wait_evt("busy_ack", t_e);
        chk("busy_ack", ack, 4'b0100);
        @(posedge clk); #2 req = 4'b0000;

        // reset mid-frame (rr pointer is now 3)
        @(posedge clk); #2 req = 4'b0001; req_data[7:0] = 8'h66;
        wait_start("mid_start", t_s);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_data", tx_data, 8'h00);
        chk("mid_rst_busy", arb_busy, 1'b0);
        chk("mid_rst_start", tx_start, 1'b0);
        @(negedge clk);
        chk("mid_rst_ack", ack, 4'b0000);
        chk("mid_rst_err", err_timeout, 1'b0);
        @(posedge clk); #2 reset_n = 1'b1; req = 4'b1001; req_data = 32'h88_00_00_77;
        wait_start("mid_after", t_s);
        chk("mid_after_grant", grant, 4'b0001);
        chk("mid_after_data", tx_data, 8'h77);
        wait_evt("mid_after_ack", t_e);
        chk("mid_after_ack", ack, 4'b0001);
        @(posedge clk); #2 req = 4'b0000;

        // randomized traffic following the requester contract
        rand_uart = 1'b1;
        repeat (4000) begin
            @(negedge clk);
            s_ack = ack;
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (s_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else req_data[8*i +: 8] = 8'($urandom);
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
        rand_uart = 1'b0;
        req = 4'b0000;
        repeat (120) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter between N_REQ independent byte sources, e.g. the RX echo path, the watch time reporter and the status/command responder.
- Round-robin arbiter with a one-byte-per-grant policy.
- Captures the winner's byte, issues one tx_start pulse, waits for tx_done, then returns an ack to that requester.
- A watchdog recovers the arbiter if tx_done never arrives.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 200_000, clk cycles to wait in WAIT_DONE before declaring a timeout. This exceeds one 10-bit frame at 9600 bps and 100 MHz (104_170 cycles).

Ports:
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level
- req_data  in  8*N_REQ  requester i's byte in bits [8*i+7:8*i]
- ack  out  N_REQ  one-hot, 1-cycle pulse: byte of requester i fully transmitted
- grant  out  N_REQ  one-hot: requester currently owning the transmitter
- err_timeout  out  1  1-cycle pulse: granted transfer abandoned by watchdog
- arb_busy  out  1  high whenever the state is not IDLE
- tx_start  out  1  1-cycle start pulse to uart_tx
- tx_data  out  8  byte to uart_tx; held stable from tx_start until tx_done
- tx_busy  in  1  from uart_tx
- tx_done  in  1  from uart_tx, 1-cycle pulse at end of stop bit

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, tx_start=0, tx_data=8'h00, grant=0, ack=0, err_timeout=0, arb_busy=0, watchdog=0.
- Reset mid-frame: the arbiter drops to IDLE immediately; no ack and no err are issued. At integration, uart_tx is reset from the same source (inverted).
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - req is sampled only in this state.
  - If req!=0 and tx_busy==0: the winner is the first set bit of req searching cyclically from rr_ptr upward (wrapping N_REQ-1 -> 0).
  - On that edge: grant<=onehot(winner), tx_data<=req_data[winner], tx_start<=1, state->ISSUE.
  - If tx_busy==1: remain in IDLE and issue nothing.
- ISSUE:
  - Exactly one cycle with tx_start=1.
  - Next edge: tx_start<=0, watchdog<=0, state->WAIT_DONE.
- WAIT_DONE:
  - grant and tx_data are held; the watchdog increments every cycle.
  - tx_done=1: ack[winner]<=1, grant<=0, rr_ptr<=(winner+1) mod N_REQ, state->GAP.
  - Else if watchdog==TIMEOUT_CYC-1: err_timeout<=1, grant<=0, rr_ptr advances as above, no ack, state->GAP.
  - tx_done and timeout on the same cycle: tx_done wins (ack, no err).
- GAP:
  - Exactly one cycle; ack or err_timeout is high during it and cleared on exit. state->IDLE.
  - This guarantees a requester can drop req before the next arbitration.
- Requester contract:
  - Hold req=1 and req_data stable until ack.
  - To send another byte, keep req=1 with new data valid on the cycle after ack.
  - req deasserted before ack is a protocol violation. A transfer that has already been captured still completes and acks.
- Latency: req rises in IDLE at cycle T -> tx_start high in cycle T+1 -> WAIT_DONE from T+2. ack arrives 1 cycle after tx_done.
- Fairness: with all requesters continuously asserting, each gets exactly one byte per round in index order. No requester waits more than N_REQ-1 frames.
- Width rules:
  - rr_ptr is $clog2(N_REQ) bits and wraps explicitly modulo N_REQ (N_REQ need not be a power of 2).
  - The watchdog is $clog2(TIMEOUT_CYC) bits and saturates only via the compare.
- tx_done received outside WAIT_DONE is ignored.

Test Plan:
- Single request: req=4'b0010, req_data[15:8]=8'hA5 -> grant=4'b0010 and tx_start pulse 1 cycle later; tx_data=8'hA5 until tx_done; ack=4'b0010 for 1 cycle; the uart_tx line shows 0xA5 LSB-first at 9600 baud.
- Simultaneous requests after reset: req=4'b1010 -> requester 1 is served first, then requester 3. Acks arrive in order 0010 then 1000, with the GAP cycle between them.
- Fairness: all four requesters held high with bytes 8'h30..8'h33 for 8 frames -> grant order 0,1,2,3,0,1,2,3; every tx_data byte matches its owner.
- Watchdog: tie tx_done=0 with a modelled uart_tx; req=4'b0001 -> err_timeout pulse exactly TIMEOUT_CYC cycles after WAIT_DONE entry; no ack; rr_ptr=1; the next request is granted normally.
- Busy gating: force tx_busy=1 while req=4'b0100 -> no tx_start and arb_busy=0. Release tx_busy -> grant 4'b0100 on the next edge.
- Reset mid-frame: assert reset_n=0 during WAIT_DONE -> all outputs go to 0 asynchronously with no ack or err. After release, req=4'b0001 is served first (rr_ptr=0).
